// File: rtl/test_result_pkg.sv
// Shared encodings for the test result arbiter: FSM states and verdict reason codes.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package test_result_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_PASSED = 2'd1,
        ST_FAILED = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        REASON_NONE     = 2'd0,
        REASON_MISMATCH = 2'd1,
        REASON_COUNT    = 2'd2,
        REASON_TIMEOUT  = 2'd3
    } fail_reason_t;

    localparam logic [15:0] TEST_COUNT_MAX = 16'hFFFF;
    localparam logic [31:0] FAIL_COUNT_MAX = 32'hFFFF_FFFF;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin one-hot arbiter; search starts at an internal pointer.
// Latency: grant is combinational from req; pointer moves on the accepting edge.
// Backpressure: pointer holds until accept, so an unserved requester keeps priority.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] req,
    input  logic               accept,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic [IDX_W-1:0] ptr;

    always_comb begin
        int j;
        j         = 0;
        grant     = '0;
        grant_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = (int'(ptr) + i) % NUM_REQ;
            if (grant == '0 && req[j]) begin
                grant[j]  = 1'b1;
                grant_idx = IDX_W'(j);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (accept) begin
            if (int'(grant_idx) == NUM_REQ - 1) begin
                ptr <= '0;
            end else begin
                ptr <= grant_idx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/test_result_arbiter.sv
// Collects checker results round-robin, logs each one, and issues a pass/fail verdict plus a delayed finish pulse.
// Latency: log_* one cycle after accept; verdict flags one cycle after all_done/timeout; finish HOLD_CYCLES after verdict.
// Backpressure: req_ready only for the single granted valid requester while running; all low once a verdict exists.
module test_result_arbiter
    import test_result_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int EXPECTED_TESTS = 16,
    parameter int TIMEOUT_CYCLES = 50000000,
    parameter int HOLD_CYCLES    = 100,
    localparam int IDX_W         = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*32-1:0] req_expected,
    input  logic [NUM_REQ*32-1:0] req_measured,
    input  logic                  all_done,
    output logic                  log_valid,
    output logic [15:0]           log_index,
    output logic [IDX_W-1:0]      log_requester,
    output logic [31:0]           log_expected,
    output logic [31:0]           log_measured,
    output logic                  log_pass,
    output logic [15:0]           test_count,
    output logic [31:0]           fail_count,
    output logic                  test_passed,
    output logic                  test_failed,
    output logic [1:0]            fail_reason,
    output logic                  finish
);

    state_t           state, state_nxt;
    fail_reason_t     reason_nxt;
    logic [NUM_REQ-1:0] arb_req, grant;
    logic [IDX_W-1:0] grant_idx;
    logic             accept;
    logic [31:0]      sel_expected, sel_measured;
    logic             sel_pass;
    logic [15:0]      tc_nxt;
    logic [31:0]      fc_nxt;
    logic [31:0]      run_timer;
    logic [31:0]      hold_cnt;
    logic             timeout_hit;

    assign arb_req   = req_valid & {NUM_REQ{state == ST_RUN}};
    assign accept    = |grant;
    assign req_ready = grant;

    rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_rr_arbiter (
        .clk       (clk),
        .reset     (reset),
        .req       (arb_req),
        .accept    (accept),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always_comb begin
        sel_expected = '0;
        sel_measured = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_expected = req_expected[32*i +: 32];
                sel_measured = req_measured[32*i +: 32];
            end
        end
    end

    assign sel_pass    = (sel_expected == sel_measured);
    assign tc_nxt      = (accept && test_count != TEST_COUNT_MAX) ? test_count + 16'd1 : test_count;
    assign fc_nxt      = (accept && !sel_pass && fail_count != FAIL_COUNT_MAX) ? fail_count + 32'd1 : fail_count;
    assign timeout_hit = (run_timer == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // The verdict looks at next-cycle counts so a result accepted alongside all_done is included.
    always_comb begin
        state_nxt  = state;
        reason_nxt = REASON_NONE;
        if (state == ST_RUN) begin
            if (all_done) begin
                if (fc_nxt != '0) begin
                    state_nxt  = ST_FAILED;
                    reason_nxt = REASON_MISMATCH;
                end else if (tc_nxt == 16'(EXPECTED_TESTS)) begin
                    state_nxt  = ST_PASSED;
                    reason_nxt = REASON_NONE;
                end else begin
                    state_nxt  = ST_FAILED;
                    reason_nxt = REASON_COUNT;
                end
            end else if (timeout_hit) begin
                state_nxt  = ST_FAILED;
                reason_nxt = REASON_TIMEOUT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            log_valid     <= 1'b0;
            log_index     <= '0;
            log_requester <= '0;
            log_expected  <= '0;
            log_measured  <= '0;
            log_pass      <= 1'b0;
            test_count    <= '0;
            fail_count    <= '0;
            test_passed   <= 1'b0;
            test_failed   <= 1'b0;
            fail_reason   <= '0;
            finish        <= 1'b0;
            run_timer     <= '0;
            hold_cnt      <= '0;
        end else begin
            log_valid <= accept;
            if (accept) begin
                log_index     <= test_count;
                log_requester <= grant_idx;
                log_expected  <= sel_expected;
                log_measured  <= sel_measured;
                log_pass      <= sel_pass;
            end
            if (state == ST_RUN) begin
                test_count <= tc_nxt;
                fail_count <= fc_nxt;
                run_timer  <= run_timer + 32'd1;
                if (state_nxt != ST_RUN) begin
                    test_passed <= (state_nxt == ST_PASSED);
                    test_failed <= (state_nxt == ST_FAILED);
                    fail_reason <= reason_nxt;
                end
            end
            // hold_cnt parks at HOLD_CYCLES so finish fires only once per verdict.
            finish <= (state != ST_RUN) && (hold_cnt == 32'(HOLD_CYCLES - 1));
            if (state != ST_RUN && hold_cnt < 32'(HOLD_CYCLES)) begin
                hold_cnt <= hold_cnt + 32'd1;
            end
        end
    end

endmodule

// File: doc/test_result_arbiter.md
TEST_RESULT_ARBITER -- requirements
Module: test_result_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of checker requesters.
REQ-002 SHALL have parameter EXPECTED_TESTS, default 16, required count of compared results.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 50000000, cycles in RUN before forced failure.
REQ-004 SHALL have parameter HOLD_CYCLES, default 100, cycles from verdict to finish pulse.
REQ-005 SHALL have ports:
  clk  input  1  single clock
  reset  input  1  synchronous, active-high
  req_valid  input  NUM_REQ  per-checker result offered
  req_ready  output  NUM_REQ  per-checker grant
  req_expected  input  NUM_REQ*32  expected values, requester i at [32*i+31:32*i]
  req_measured  input  NUM_REQ*32  measured values, same packing
  all_done  input  1  pulse: stimulus finished
  log_valid  output  1  one-cycle pulse: one result logged
  log_index  output  16  test_count value before this result
  log_requester  output  clog2(NUM_REQ)  granted requester
  log_expected / log_measured  output  32 each  granted values
  log_pass  output  1  expected == measured
  test_count  output  16  accepted results, saturating
  fail_count  output  32  mismatches, saturating
  test_passed / test_failed  output  1 each  sticky verdicts
  fail_reason  output  2  0 none, 1 mismatch, 2 count, 3 timeout
  finish  output  1  one-cycle pulse HOLD_CYCLES after verdict

Function
REQ-006 SHALL implement states RUN, PASSED, FAILED; RUN on reset.
REQ-007 SHALL in RUN grant at most one requester per cycle, round-robin, starting search at pointer.
REQ-008 SHALL drive req_ready combinationally: only the granted requester high, and only when its req_valid is high.
REQ-009 SHALL advance the pointer to granted+1, mod NUM_REQ, on each accept; unchanged otherwise.
REQ-010 SHALL on accept register log_* and pulse log_valid the next cycle (latency 1).
REQ-011 SHALL on accept increment test_count, saturating at 0xFFFF, and increment fail_count on mismatch, saturating at 0xFFFFFFFF.
REQ-012 SHALL on all_done in RUN evaluate counts including any same-cycle accept: fail_count!=0 -> FAILED, reason 1; else test_count==EXPECTED_TESTS -> PASSED, reason 0; else FAILED, reason 2.
REQ-013 SHALL count RUN cycles; on reaching TIMEOUT_CYCLES-1 without all_done -> FAILED, reason 3; all_done in the same cycle wins.
REQ-014 SHALL assert test_passed or test_failed on the cycle after the transition and hold it until reset.
REQ-015 SHALL in PASSED/FAILED hold all req_ready low, ignore all_done and freeze counters.
REQ-016 SHALL pulse finish exactly once, HOLD_CYCLES cycles after the verdict asserts.

Reset
REQ-017 SHALL on reset clear all outputs, counters, pointer, timer and hold counter to 0, state RUN; reset overrides every same-cycle event, including mid-hold.

Structure
REQ-018 SHALL place state encoding and fail_reason codes in shared package test_result_pkg.
REQ-019 SHALL instantiate sub-module rr_arbiter (NUM_REQ-wide request, grant one-hot, pointer update on accept).

Verification
REQ-020 Directed scenarios the bench SHALL cover:
  - all 4 valid continuously, 16 matching results -> grants 0,1,2,3,0,...; test_count=16; all_done -> test_passed=1, fail_reason=0, finish 100 cycles later.
  - requester 2 offers expected 0x12345678, measured 0x12345679 -> log_pass=0, fail_count=1; all_done -> test_failed=1, fail_reason=1.
  - 15 matching results then all_done -> test_failed=1, fail_reason=2.
  - TIMEOUT_CYCLES=1000, no all_done -> test_failed=1, fail_reason=3 at RUN cycle 999; all_done on cycle 999 -> verdict from counts instead.
  - 16th accept and all_done in the same cycle -> test_passed=1.
  - reset asserted during hold -> no finish pulse; all outputs 0; pointer back to 0.
